// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style pipeline front end and decode.
// Holds the NOP encoding, opcode/func constants and the fetch FSM state type.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    // Sequential PC increment; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: valid, instruction and pc+4 of the fetched word.
// Flush (and reset) write an all-zero bubble; otherwise load or hold.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;

    // Bubble on reset/flush, capture on load, otherwise keep contents.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Pipeline front end: owns the PC, fetches over a req/ready handshake,
// applies redirects and stalls, and feeds decode through the IF/ID register.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic [5:0]  if_id_opcode,
    output logic [5:0]  if_id_func
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  tgt_q, tgt_d;
    logic [31:0]  hbuf_instr_q, hbuf_instr_d;
    logic [31:0]  hbuf_pc4_q, hbuf_pc4_d;
    logic         req_en_q;

    logic         redir;
    logic [31:0]  redir_tgt;
    logic         rdy;

    logic         id_flush;
    logic         id_load;
    logic [31:0]  id_instr;
    logic [31:0]  id_pc4;

    // Older EX branch wins over the younger ID jump.
    assign redir     = br_taken | jmp;
    assign redir_tgt = br_taken ? br_target : jmp_target;

    // The first cycle out of reset issues no request, so imem_req reads 0.
    assign imem_req  = req_en_q & (state_q != HOLD);
    assign imem_addr = pc_q;
    assign rdy       = imem_req & imem_ready;

    // State register: FSM state, PC, latched target and hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            tgt_q        <= RESET_PC;
            hbuf_instr_q <= NOP_INSTR;
            hbuf_pc4_q   <= 32'h0;
            req_en_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            hbuf_instr_q <= hbuf_instr_d;
            hbuf_pc4_q   <= hbuf_pc4_d;
            req_en_q     <= 1'b1;
        end
    end

    // Next-state and PC selection; redirect outranks stall everywhere.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        hbuf_instr_d = hbuf_instr_q;
        hbuf_pc4_d   = hbuf_pc4_q;
        unique case (state_q)
            RUN: begin
                if (redir) begin
                    if (rdy || !imem_req) begin
                        pc_d = redir_tgt;
                    end else begin
                        tgt_d   = redir_tgt;
                        state_d = KILL;
                    end
                end else if (rdy) begin
                    pc_d = pc_plus4(pc_q);
                    if (stall) begin
                        hbuf_instr_d = imem_rdata;
                        hbuf_pc4_d   = pc_plus4(pc_q);
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d         = redir_tgt;
                    hbuf_instr_d = NOP_INSTR;
                    hbuf_pc4_d   = 32'h0;
                    state_d      = RUN;
                end else if (!stall) begin
                    state_d = RUN;
                end
            end
            KILL: begin
                if (redir) begin
                    tgt_d = redir_tgt;
                end
                if (rdy) begin
                    pc_d    = redir ? redir_tgt : tgt_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // IF/ID control: load a real word, insert a bubble, or hold.
    always_comb begin
        id_flush = 1'b0;
        id_load  = 1'b0;
        id_instr = imem_rdata;
        id_pc4   = pc_plus4(pc_q);
        unique case (state_q)
            RUN: begin
                id_flush = redir | (!rdy & !stall);
                id_load  = rdy & !stall & !redir;
            end
            HOLD: begin
                id_flush = redir;
                id_load  = !redir & !stall;
                id_instr = hbuf_instr_q;
                id_pc4   = hbuf_pc4_q;
            end
            KILL: begin
                id_flush = 1'b1;
            end
            default: begin
                id_flush = 1'b1;
            end
        endcase
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .rst     (rst),
        .flush_i (id_flush),
        .load_i  (id_load),
        .instr_i (id_instr),
        .pc4_i   (id_pc4),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4)
    );

    assign pc           = pc_q;
    assign if_id_opcode = if_id_instr[31:26];
    assign if_id_func   = if_id_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic,
// all compared cycle by cycle against a behavioural front-end model.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        jmp = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  if_id_opcode;
    logic [5:0]  if_id_func;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp          (jmp),
        .jmp_target   (jmp_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .pc           (pc),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_opcode (if_id_opcode),
        .if_id_func   (if_id_func)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference front end: what decode should see, tracked per cycle.
    bit          m_known = 0;
    bit          m_boot = 0;
    bit          m_held = 0;
    bit          m_kill = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ktgt = 32'h0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_hp4 = 32'h0;
    bit          m_valid = 0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc4 = 32'h0;

    int wait_left = -1;
    int lat_force = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h0109_5020;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic bubble();
        m_valid = 0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
    endtask

    task automatic cyc(input bit r, input bit s, input bit b,
                       input logic [31:0] bt, input bit j,
                       input logic [31:0] jt);
        bit          exp_req;
        bit          rd;
        bit          rdir;
        logic [31:0] tg;
        int          pick;
        @(negedge clk);
        rst        = r;
        stall      = s;
        br_taken   = b;
        br_target  = bt;
        jmp        = j;
        jmp_target = jt;
        if (imem_req === 1'b1) begin
            if (wait_left < 0) begin
                pick = $urandom_range(0, 5);
                wait_left = (lat_force >= 0) ? lat_force
                          : ((pick > 3) ? 0 : pick);
            end
            if (wait_left == 0) begin
                imem_ready = 1'b1;
                imem_rdata = mem_word(imem_addr);
                wait_left  = -1;
            end else begin
                imem_ready = 1'b0;
                imem_rdata = $urandom;
                wait_left--;
            end
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            wait_left  = -1;
        end
        #1;
        exp_req = m_boot && !m_held;
        if (m_known) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
        end
        rd   = imem_ready && exp_req;
        rdir = b || j;
        tg   = b ? bt : jt;
        if (r) begin
            m_known = 1;
            m_pc    = 32'h0;
            m_held  = 0;
            m_kill  = 0;
            m_boot  = 0;
            bubble();
        end else begin
            if (m_held) begin
                if (rdir) begin
                    m_held = 0;
                    m_pc   = tg;
                    bubble();
                end else if (!s) begin
                    m_held  = 0;
                    m_valid = 1;
                    m_instr = m_hi;
                    m_pc4   = m_hp4;
                end
            end else if (m_kill) begin
                bubble();
                if (rdir) m_ktgt = tg;
                if (rd) begin
                    m_pc   = m_ktgt;
                    m_kill = 0;
                end
            end else if (rdir) begin
                bubble();
                if (rd || !exp_req) begin
                    m_pc = tg;
                end else begin
                    m_kill = 1;
                    m_ktgt = tg;
                end
            end else if (rd) begin
                if (s) begin
                    m_held = 1;
                    m_hi   = imem_rdata;
                    m_hp4  = m_pc + 32'd4;
                end else begin
                    m_valid = 1;
                    m_instr = imem_rdata;
                    m_pc4   = m_pc + 32'd4;
                end
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                bubble();
            end
            m_boot = 1;
        end
        @(posedge clk);
        #1;
        chk("pc", pc, m_pc);
        chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_opcode", {26'b0, if_id_opcode}, {26'b0, m_instr[31:26]});
        chk("if_id_func", {26'b0, if_id_func}, {26'b0, m_instr[5:0]});
    endtask

    task automatic idle(input bit s);
        cyc(1'b0, s, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        bit          r, s, b, j;
        logic [31:0] bt, jt;

        lat_force = 0;
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        idle(1'b0);
        idle(1'b0);
        chk("first_instr", if_id_instr, 32'h2008_0005);
        chk("first_pc4", if_id_pc4, 32'h4);
        idle(1'b0);
        chk("second_instr", if_id_instr, 32'h0109_5020);
        chk("pc_after_two", pc, 32'h8);

        lat_force = 3;
        repeat (4) idle(1'b0);

        lat_force = 0;
        idle(1'b1);
        idle(1'b1);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        idle(1'b0);

        lat_force = 3;
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h80);
        idle(1'b0);
        idle(1'b0);
        chk("kill_pc", pc, 32'h40);
        chk("kill_addr", imem_addr, 32'h40);
        chk("kill_valid", {31'b0, if_id_valid}, 32'h0);
        chk("kill_opcode", {26'b0, if_id_opcode}, 32'h0);
        chk("kill_func", {26'b0, if_id_func}, 32'h0);

        lat_force = 0;
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap_tgt", pc, 32'hFFFF_FFFC);
        idle(1'b0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_valid", {31'b0, if_id_valid}, 32'h1);

        lat_force = 3;
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("krst_pc", pc, 32'h0);
        chk("krst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("krst_req", {31'b0, imem_req}, 32'h0);

        lat_force = -1;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 11) == 0);
            j  = ($urandom_range(0, 11) == 0);
            bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8
               : (32'($urandom_range(0, 255)) << 2);
            jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC
               : (32'($urandom_range(0, 255)) << 2);
            cyc(r, s, b, bt, j, jt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
